// File: rtl/trdemu_xchg.sv
// Emulator-side VG93 exchange block: captures trapped host VG accesses, hands them to
// the emulation code, releases the trap and optionally replays a response byte.
module trdemu_xchg #(
  parameter int REPLAY_TMO = 4096,
  parameter int TMO_W      = 12
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       trap_stb,
  input  logic       trap_wr,
  input  logic [1:0] trap_a,
  input  logic [7:0] trap_wdata,
  input  logic       emu_rd_stb,
  input  logic       emu_wr_stb,
  input  logic [1:0] emu_port,
  input  logic [7:0] emu_wdata,
  output logic [7:0] emu_rdata,
  input  logic       host_rd_stb,
  input  logic [1:0] host_a,
  output logic [7:0] host_rdata,
  output logic       host_rdata_oe,
  output logic       clr_nmi,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRAPPED = 2'd1,
    ST_REPLAY  = 2'd2
  } state_e;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(REPLAY_TMO - 1);

  state_e             state_q, state_d;
  logic               cap_wr_q, cap_wr_d;
  logic [1:0]         cap_a_q, cap_a_d;
  logic [7:0]         cap_data_q, cap_data_d;
  logic [7:0]         resp_q, resp_d;
  logic               resp_valid_q, resp_valid_d;
  logic               overrun_q, overrun_d;
  logic               clr_nmi_q, clr_nmi_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  logic               wr_p2_s;
  logic               wr_p3_s;
  logic               rd_p0_s;
  logic               ovr_set_s;

  assign wr_p2_s   = emu_wr_stb && (emu_port == 2'd2);
  assign wr_p3_s   = emu_wr_stb && (emu_port == 2'd3);
  assign rd_p0_s   = emu_rd_stb && (emu_port == 2'd0);
  assign ovr_set_s = (state_q == ST_TRAPPED) && trap_stb;

  // State and datapath registers
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cap_wr_q     <= 1'b0;
      cap_a_q      <= 2'd0;
      cap_data_q   <= 8'd0;
      resp_q       <= 8'd0;
      resp_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      clr_nmi_q    <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      cap_wr_q     <= cap_wr_d;
      cap_a_q      <= cap_a_d;
      cap_data_q   <= cap_data_d;
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
      overrun_q    <= overrun_d;
      clr_nmi_q    <= clr_nmi_d;
      tmo_q        <= tmo_d;
    end
  end

  // Next-state logic for the trap / release / replay sequence
  always_comb begin
    state_d      = state_q;
    cap_wr_d     = cap_wr_q;
    cap_a_d      = cap_a_q;
    cap_data_d   = cap_data_q;
    resp_d       = resp_q;
    resp_valid_d = resp_valid_q;
    tmo_d        = tmo_q;
    clr_nmi_d    = 1'b0;
    // a fresh overrun beats a same-cycle status read that would clear it
    overrun_d    = ovr_set_s ? 1'b1 : (rd_p0_s ? 1'b0 : overrun_q);

    case (state_q)
      ST_IDLE: begin
        if (trap_stb) begin
          cap_wr_d     = trap_wr;
          cap_a_d      = trap_a;
          cap_data_d   = trap_wdata;
          resp_valid_d = 1'b0;
          state_d      = ST_TRAPPED;
        end else begin
          state_d      = ST_IDLE;
        end
      end
      ST_TRAPPED: begin
        if (wr_p2_s) begin
          resp_d       = emu_wdata;
          resp_valid_d = 1'b1;
        end else begin
          resp_valid_d = resp_valid_q;
        end
        if (wr_p3_s) begin
          clr_nmi_d = 1'b1;
          if (emu_wdata[0] && !cap_wr_q && resp_valid_q) begin
            state_d = ST_REPLAY;
            tmo_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_TRAPPED;
        end
      end
      ST_REPLAY: begin
        if (trap_stb) begin
          cap_wr_d     = trap_wr;
          cap_a_d      = trap_a;
          cap_data_d   = trap_wdata;
          resp_valid_d = 1'b0;
          state_d      = ST_TRAPPED;
        end else if (host_rd_stb && (host_a == cap_a_q)) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          tmo_d        = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Exchange port read mux
  always_comb begin
    emu_rdata = 8'hFF;
    case (emu_port)
      2'd0:    emu_rdata = {busy, overrun_q, resp_valid_q, cap_wr_q, 2'b00, cap_a_q};
      2'd1:    emu_rdata = cap_data_q;
      2'd2:    emu_rdata = resp_q;
      2'd3:    emu_rdata = 8'hFF;
      default: emu_rdata = 8'hFF;
    endcase
  end

  assign busy          = (state_q == ST_TRAPPED);
  assign overrun       = overrun_q;
  assign clr_nmi       = clr_nmi_q;
  assign host_rdata    = resp_q;
  assign host_rdata_oe = (state_q == ST_REPLAY) && (host_a == cap_a_q);

endmodule

// File: tb/tb_trdemu_xchg.sv
// Directed bench for trdemu_xchg with a short replay timeout.
module tb_trdemu_xchg;

  logic       fclk = 1'b0;
  logic       rst_n;
  logic       trap_stb, trap_wr;
  logic [1:0] trap_a;
  logic [7:0] trap_wdata;
  logic       emu_rd_stb, emu_wr_stb;
  logic [1:0] emu_port;
  logic [7:0] emu_wdata;
  logic [7:0] emu_rdata;
  logic       host_rd_stb;
  logic [1:0] host_a;
  logic [7:0] host_rdata;
  logic       host_rdata_oe, clr_nmi, busy, overrun;

  int errors = 0;
  int checks = 0;

  trdemu_xchg #(.REPLAY_TMO(16), .TMO_W(4)) dut (
    .fclk(fclk), .rst_n(rst_n),
    .trap_stb(trap_stb), .trap_wr(trap_wr), .trap_a(trap_a), .trap_wdata(trap_wdata),
    .emu_rd_stb(emu_rd_stb), .emu_wr_stb(emu_wr_stb), .emu_port(emu_port),
    .emu_wdata(emu_wdata), .emu_rdata(emu_rdata),
    .host_rd_stb(host_rd_stb), .host_a(host_a), .host_rdata(host_rdata),
    .host_rdata_oe(host_rdata_oe), .clr_nmi(clr_nmi), .busy(busy), .overrun(overrun)
  );

  always #5 fclk = ~fclk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic trap(input logic wr, input logic [1:0] a, input logic [7:0] d);
    trap_stb = 1'b1; trap_wr = wr; trap_a = a; trap_wdata = d;
    tick();
    trap_stb = 1'b0;
  endtask

  task automatic emu_wr(input logic [1:0] p, input logic [7:0] d);
    emu_wr_stb = 1'b1; emu_port = p; emu_wdata = d;
    tick();
    emu_wr_stb = 1'b0;
  endtask

  task automatic emu_rd(input logic [1:0] p, input logic [7:0] exp, input string tag);
    emu_rd_stb = 1'b1; emu_port = p;
    #1;
    chk(tag, emu_rdata, exp);
    tick();
    emu_rd_stb = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    trap_stb = 1'b0; trap_wr = 1'b0; trap_a = 2'd0; trap_wdata = 8'h00;
    emu_rd_stb = 1'b0; emu_wr_stb = 1'b0; emu_port = 2'd0; emu_wdata = 8'h00;
    host_rd_stb = 1'b0; host_a = 2'd0;
    #1;
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_oe", {7'd0, host_rdata_oe}, 8'h00);
    chk("rst_clr", {7'd0, clr_nmi}, 8'h00);
    chk("rst_port0", emu_rdata, 8'h00);
    repeat (2) @(posedge fclk);
    #1 rst_n = 1'b1;
    tick();

    // host write trap, release without replay
    trap(1'b1, 2'd3, 8'h18);
    chk("wr_busy", {7'd0, busy}, 8'h01);
    emu_rd(2'd0, 8'h93, "wr_port0");
    emu_rd(2'd1, 8'h18, "wr_port1");
    emu_rd(2'd3, 8'hFF, "port3_rd");
    host_a = 2'd3;
    emu_wr(2'd3, 8'h01);
    chk("wr_clr_pulse", {7'd0, clr_nmi}, 8'h01);
    chk("wr_idle", {7'd0, busy}, 8'h00);
    chk("wr_no_oe", {7'd0, host_rdata_oe}, 8'h00);
    tick();
    chk("wr_clr_end", {7'd0, clr_nmi}, 8'h00);

    // writes outside TRAPPED are ignored
    emu_wr(2'd2, 8'hEE);
    emu_wr(2'd3, 8'h01);
    chk("idle_wr3_noclr", {7'd0, clr_nmi}, 8'h00);
    emu_rd(2'd2, 8'h00, "idle_wr2_ign");

    // read replay
    trap(1'b0, 2'd2, 8'h00);
    emu_rd(2'd0, 8'h82, "rp_port0");
    emu_wr(2'd2, 8'h5A);
    emu_rd(2'd0, 8'hA2, "rp_port0_rv");
    emu_rd(2'd2, 8'h5A, "rp_port2");
    emu_wr(2'd3, 8'h01);
    chk("rp_clr_pulse", {7'd0, clr_nmi}, 8'h01);
    tick();
    chk("rp_clr_end", {7'd0, clr_nmi}, 8'h00);
    host_a = 2'd1;
    #1;
    chk("rp_oe_other", {7'd0, host_rdata_oe}, 8'h00);
    host_rd_stb = 1'b1;
    tick();
    host_rd_stb = 1'b0;
    host_a = 2'd2;
    #1;
    chk("rp_oe_match", {7'd0, host_rdata_oe}, 8'h01);
    chk("rp_data", host_rdata, 8'h5A);
    host_rd_stb = 1'b1;
    tick();
    host_rd_stb = 1'b0;
    chk("rp_done_oe", {7'd0, host_rdata_oe}, 8'h00);
    emu_rd(2'd0, 8'h02, "rp_done_port0");

    // overrun keeps first capture, status read clears it
    trap(1'b0, 2'd1, 8'h11);
    trap(1'b1, 2'd0, 8'hFF);
    chk("ovr_flag", {7'd0, overrun}, 8'h01);
    emu_rd(2'd1, 8'h11, "ovr_keep_data");
    emu_rd(2'd0, 8'hC1, "ovr_port0");
    emu_rd(2'd0, 8'h81, "ovr_cleared");
    emu_wr(2'd3, 8'h00);
    chk("ovr_rel_clr", {7'd0, clr_nmi}, 8'h01);
    tick();

    // same-cycle trap and release
    trap(1'b0, 2'd1, 8'h22);
    trap_stb = 1'b1; trap_wr = 1'b1; trap_a = 2'd3; trap_wdata = 8'h99;
    emu_wr(2'd3, 8'h01);
    trap_stb = 1'b0;
    chk("sim_clr", {7'd0, clr_nmi}, 8'h01);
    chk("sim_idle", {7'd0, busy}, 8'h00);
    emu_rd(2'd0, 8'h41, "sim_port0");
    emu_rd(2'd0, 8'h01, "sim_port0_clr");
    emu_rd(2'd1, 8'h22, "sim_keep_data");

    // replay timeout after exactly 16 cycles
    trap(1'b0, 2'd0, 8'h00);
    emu_wr(2'd2, 8'h33);
    host_a = 2'd0;
    emu_wr(2'd3, 8'h01);
    chk("tmo_clr", {7'd0, clr_nmi}, 8'h01);
    chk("tmo_armed_oe", {7'd0, host_rdata_oe}, 8'h01);
    repeat (15) tick();
    chk("tmo_15_oe", {7'd0, host_rdata_oe}, 8'h01);
    tick();
    chk("tmo_16_oe", {7'd0, host_rdata_oe}, 8'h00);
    host_rd_stb = 1'b1;
    #1;
    chk("tmo_late_oe", {7'd0, host_rdata_oe}, 8'h00);
    tick();
    host_rd_stb = 1'b0;
    emu_rd(2'd0, 8'h00, "tmo_port0");

    // release without response
    trap(1'b0, 2'd3, 8'h00);
    host_a = 2'd3;
    emu_wr(2'd3, 8'h01);
    chk("nr_clr", {7'd0, clr_nmi}, 8'h01);
    chk("nr_idle", {7'd0, busy}, 8'h00);
    chk("nr_oe", {7'd0, host_rdata_oe}, 8'h00);
    tick();

    // reset in the middle of a replay
    trap(1'b0, 2'd2, 8'h00);
    trap(1'b0, 2'd1, 8'h00);
    emu_wr(2'd2, 8'h77);
    host_a = 2'd2;
    emu_wr(2'd3, 8'h01);
    chk("mr_armed_oe", {7'd0, host_rdata_oe}, 8'h01);
    chk("mr_armed_ovr", {7'd0, overrun}, 8'h01);
    rst_n = 1'b0;
    emu_port = 2'd2;
    #1;
    chk("mr_oe", {7'd0, host_rdata_oe}, 8'h00);
    chk("mr_busy", {7'd0, busy}, 8'h00);
    chk("mr_ovr", {7'd0, overrun}, 8'h00);
    chk("mr_clr", {7'd0, clr_nmi}, 8'h00);
    chk("mr_resp", emu_rdata, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
